fetch_queue: RTL and testbench

- Instruction-fetch stage directly downstream of the PC apparatus.
- Takes the current PC each cycle and issues in-order read requests to instruction memory over a valid/ready interface with variable response latency.
- Buffers returned instruction words with their PCs in a small FIFO for decode.
- Back-pressures the PC apparatus through pc_advance, and flushes all buffered and in-flight fetches on a branch/jump redirect.

---
 rtl/fetch_queue_pkg.sv | 23 ++
 rtl/fetch_queue_if.sv | 36 +++
 rtl/fetch_queue_sync_fifo.sv | 68 ++++++
 rtl/fetch_queue.sv | 140 ++++++++++++++
 tb/tb_fetch_queue.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction-fetch queue: default widths,
// the cleared-instruction constant and the request credit check.
package fetch_queue_pkg;

    localparam int FQ_DBITS   = 32;
    localparam int FQ_IBITS   = 32;
    localparam int FQ_DEPTH   = 4;
    localparam int FQ_MAX_OUT = 4;

    // Word presented on inst_data whenever the queue head is not valid.
    localparam logic [31:0] INST_NOP = 32'h0;

    // A new request may issue only if its eventual response is guaranteed a
    // queue slot and the in-flight tracking (live plus discarded) has room.
    function automatic logic creditAvailable(input int qCount,
                                             input int outstanding,
                                             input int discard,
                                             input int depth,
                                             input int maxOut);
        return ((qCount + outstanding) < depth) && ((outstanding + discard) < maxOut);
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Bundle of the PC-side, memory-side and decode-side signals of the fetch
// queue. The master modport is the fetch queue itself; the slave modport is
// the surrounding PC apparatus, instruction memory and decode stage.
interface fetch_queue_if
    import fetch_queue_pkg::*;
#(
    parameter int DBITS = FQ_DBITS,
    parameter int IBITS = FQ_IBITS
);

    logic [DBITS-1:0] pc_in;
    logic             pc_advance;
    logic             redirect;

    logic             mem_req_valid;
    logic [DBITS-1:0] mem_req_addr;
    logic             mem_req_ready;
    logic             mem_resp_valid;
    logic [IBITS-1:0] mem_resp_data;

    logic             inst_valid;
    logic [IBITS-1:0] inst_data;
    logic [DBITS-1:0] inst_pc;
    logic             inst_ready;

    modport master (
        input  pc_in, redirect, mem_req_ready, mem_resp_valid, mem_resp_data, inst_ready,
        output pc_advance, mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc
    );

    modport slave (
        output pc_in, redirect, mem_req_ready, mem_resp_valid, mem_resp_data, inst_ready,
        input  pc_advance, mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc
    );

endinterface

// File: rtl/fetch_queue_sync_fifo.sv
// Small synchronous FIFO with push/pop/clear and a combinational head.
// Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rdPtr_q;
    logic [PW-1:0]    wrPtr_q;
    logic [CW-1:0]    count_q;
    logic             doPush;
    logic             doPop;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(DEPTH));
    assign count  = count_q;
    assign rdata  = mem_q[rdPtr_q];
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);

    // Storage carries no reset; validity is tracked purely by count_q.
    always_ff @(posedge clk) begin
        if (doPush && !clear) begin
            mem_q[wrPtr_q] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; clear empties the FIFO in one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else if (clear) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= nextPtr(wrPtr_q);
            end
            if (doPop) begin
                rdPtr_q <= nextPtr(rdPtr_q);
            end
            count_q <= count_q + CW'(doPush) - CW'(doPop);
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch queue: issues in-order fetches at pc_in, tags them with
// their PC, buffers returned words for decode and discards responses that
// belong to fetches flushed by a redirect.
// Optional build macro FETCH_PERF_EN adds the perf_stall / perf_drop counters.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DBITS   = FQ_DBITS,
    parameter int IBITS   = FQ_IBITS,
    parameter int DEPTH   = FQ_DEPTH,
    parameter int MAX_OUT = FQ_MAX_OUT
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]   perf_stall,
    output logic [31:0]   perf_drop
`endif
);

    localparam int QCW = $clog2(DEPTH) + 1;
    localparam int OCW = $clog2(MAX_OUT) + 1;
    localparam int EW  = DBITS + IBITS;

    logic [QCW-1:0]   qCount;
    logic             qEmpty;
    logic             qFull;
    logic [EW-1:0]    qHead;
    logic [OCW-1:0]   tagCount;
    logic             tagEmpty;
    logic             tagFull;
    logic [DBITS-1:0] tagHead;
    logic [OCW-1:0]   discard_q;
    logic [OCW-1:0]   discard_d;
    logic             room;
    logic             reqValid;
    logic             accept;
    logic             respDrop;
    logic             respDeliver;
    logic             respCounted;
    logic             instValid;
    logic             unusedFlags;

    // The tag FIFO occupancy is exactly the number of live outstanding fetches.
    assign room        = creditAvailable(int'(qCount), int'(tagCount), int'(discard_q), DEPTH, MAX_OUT);
    assign reqValid    = reset && room && !bus.redirect;
    assign accept      = reqValid && bus.mem_req_ready;
    assign respDrop    = bus.mem_resp_valid && (discard_q != '0);
    assign respDeliver = bus.mem_resp_valid && (discard_q == '0) && !tagEmpty;
    assign respCounted = respDrop || respDeliver;
    assign instValid   = !qEmpty;
    assign unusedFlags = qFull ^ tagFull;

    assign bus.mem_req_valid = reqValid;
    assign bus.mem_req_addr  = bus.pc_in;
    assign bus.pc_advance    = accept;
    assign bus.inst_valid    = instValid;
    assign bus.inst_pc       = qEmpty ? '0 : qHead[EW-1:IBITS];
    assign bus.inst_data     = qEmpty ? IBITS'(INST_NOP) : qHead[IBITS-1:0];

    // On redirect every live fetch becomes one to discard, minus any response consumed now.
    always_comb begin
        discard_d = discard_q;
        if (bus.redirect) begin
            discard_d = discard_q + tagCount - OCW'(respCounted);
        end else if (respDrop) begin
            discard_d = discard_q - 1'b1;
        end
    end

    // Count of stale responses still to be swallowed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            discard_q <= '0;
        end else begin
            discard_q <= discard_d;
        end
    end

    sync_fifo #(
        .WIDTH (DBITS),
        .DEPTH (MAX_OUT)
    ) u_tagFifo (
        .clk   (clk),
        .reset (reset),
        .clear (bus.redirect),
        .push  (accept),
        .pop   (respDeliver),
        .wdata (bus.pc_in),
        .rdata (tagHead),
        .full  (tagFull),
        .empty (tagEmpty),
        .count (tagCount)
    );

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_instQueue (
        .clk   (clk),
        .reset (reset),
        .clear (bus.redirect),
        .push  (respDeliver),
        .pop   (instValid && bus.inst_ready),
        .wdata ({tagHead, bus.mem_resp_data}),
        .rdata (qHead),
        .full  (qFull),
        .empty (qEmpty),
        .count (qCount)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] stall_q;
    logic [31:0] drop_q;
    logic        dropNow;

    // A word delivered in a redirect cycle is flushed too, so it counts as dropped.
    assign dropNow    = respDrop || (bus.redirect && respDeliver);
    assign perf_stall = stall_q;
    assign perf_drop  = drop_q;

    // Saturating stall and dropped-response counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
            drop_q  <= '0;
        end else begin
            if (reqValid && !bus.mem_req_ready && (stall_q != '1)) begin
                stall_q <= stall_q + 32'd1;
            end
            if (dropNow && (drop_q != '1)) begin
                drop_q <= drop_q + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with an in-order variable-latency memory
// model, a PC stepper and a scoreboard of expected {pc, word} pairs.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    logic clk;
    logic reset;

    fetch_queue_if #(.DBITS(32), .IBITS(32)) bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] perfStall;
    logic [31:0] perfDrop;
`endif

    fetch_queue #(
        .DBITS   (32),
        .IBITS   (32),
        .DEPTH   (4),
        .MAX_OUT (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_stall (perfStall),
        .perf_drop  (perfDrop)
`endif
    );

    int          testCount    = 0;
    int          failCount    = 0;
    int          cycle        = 0;
    int          memLat       = 1;
    int          acceptCount  = 0;
    int          consumeCount = 0;
    logic [31:0] memAddrQ[$];
    int          memDueQ[$];
    logic [63:0] expQ[$];
    logic [31:0] logPc[$];
    int          logCyc[$];

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkLog(input string tag, input int idx, input logic [31:0] expPc);
        checkOutput({tag, "_present"}, 64'(logPc.size() > idx), 64'd1);
        if (logPc.size() > idx) begin
            checkOutput(tag, logPc[idx], expPc);
        end
    endtask

    // Run n clock cycles: monitor/score on the falling edge, then step the
    // PC, drop a one-shot redirect and drive the next memory response.
    task automatic applyStimulus(input int n);
        for (int k = 0; k < n; k++) begin
            logic        adv;
            logic [63:0] e;
            @(negedge clk);
            adv = bus.pc_advance;
            if (bus.mem_req_valid) begin
                checkOutput("req_addr", bus.mem_req_addr, bus.pc_in);
            end
            if (bus.redirect) begin
                expQ.delete();
            end else if (bus.inst_valid && bus.inst_ready) begin
                checkOutput("sb_has_entry", 64'(expQ.size() > 0), 64'd1);
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    checkOutput("sb_inst_pc", bus.inst_pc, e[63:32]);
                    checkOutput("sb_inst_data", bus.inst_data, e[31:0]);
                end
                logPc.push_back(bus.inst_pc);
                logCyc.push_back(cycle);
                consumeCount++;
            end
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                memAddrQ.push_back(bus.mem_req_addr);
                memDueQ.push_back(cycle + memLat);
                expQ.push_back({bus.pc_in, bus.pc_in + 32'hA0});
                acceptCount++;
            end
            @(posedge clk);
            cycle++;
            #1;
            bus.redirect = 1'b0;
            if (adv) begin
                bus.pc_in = bus.pc_in + 32'd4;
            end
            if ((memAddrQ.size() > 0) && (memDueQ[0] <= cycle)) begin
                bus.mem_resp_valid = 1'b1;
                bus.mem_resp_data  = memAddrQ.pop_front() + 32'hA0;
                void'(memDueQ.pop_front());
            end else begin
                bus.mem_resp_valid = 1'b0;
                bus.mem_resp_data  = 32'h0;
            end
        end
    endtask

    task automatic drain();
        bus.mem_req_ready = 1'b0;
        bus.inst_ready    = 1'b1;
        applyStimulus(8);
    endtask

    // Three fetches in flight at latency 5, then redirect to target.
    task automatic redirectScenario(input logic [31:0] base, input logic [31:0] target, input string tag);
        int idx;
        bus.pc_in    = base;
        bus.redirect = 1'b1;
        applyStimulus(1);
        memLat            = 5;
        bus.inst_ready    = 1'b1;
        bus.mem_req_ready = 1'b1;
        applyStimulus(3);
        bus.mem_req_ready = 1'b0;
        applyStimulus(1);
        bus.pc_in    = target;
        bus.redirect = 1'b1;
        applyStimulus(1);
        checkOutput({tag, "_discard"}, dut.discard_q, 64'd3);
        bus.mem_req_ready = 1'b1;
        memLat            = 1;
        idx               = logPc.size();
        applyStimulus(12);
        checkLog({tag, "_first_pc"}, idx, target);
        checkLog({tag, "_second_pc"}, idx + 1, target + 32'd4);
    endtask

    initial begin
        int          idx;
        int          c0;
        logic [31:0] startPc;

        reset              = 1'b0;
        bus.pc_in          = 32'h40;
        bus.redirect       = 1'b0;
        bus.mem_req_ready  = 1'b1;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = 32'h0;
        bus.inst_ready     = 1'b1;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_inst_valid", bus.inst_valid, 64'd0);
        checkOutput("rst_inst_data", bus.inst_data, 64'd0);
        checkOutput("rst_inst_pc", bus.inst_pc, 64'd0);
        checkOutput("rst_req_valid", bus.mem_req_valid, 64'd0);
        checkOutput("rst_pc_advance", bus.pc_advance, 64'd0);
        reset = 1'b1;

        // Streaming fetch from 0x40 with 1-cycle memory.
        applyStimulus(8);
        checkLog("t1_pc0", 0, 32'h40);
        checkLog("t1_pc1", 1, 32'h44);
        checkLog("t1_pc2", 2, 32'h48);
        checkLog("t1_pc3", 3, 32'h4C);
        if (logCyc.size() >= 4) begin
            for (int i = 1; i < 4; i++) begin
                checkOutput("t1_no_bubble", logCyc[i], logCyc[0] + i);
            end
        end

        // Decode stalls: queue fills to DEPTH then fetching stops.
        bus.inst_ready = 1'b0;
        applyStimulus(10);
        checkOutput("t2_in_queue", acceptCount - consumeCount, 64'd4);
        checkOutput("t2_req_valid", bus.mem_req_valid, 64'd0);
        checkOutput("t2_pc_advance", bus.pc_advance, 64'd0);
        checkOutput("t2_inst_valid", bus.inst_valid, 64'd1);
        c0             = consumeCount;
        bus.inst_ready = 1'b1;
        applyStimulus(10);
        checkOutput("t2_resume", 64'(consumeCount > c0 + 4), 64'd1);

        // Redirect with three fetches in flight.
        drain();
        redirectScenario(32'h50, 32'h64, "t3");

        // Redirect coinciding with a response, two outstanding.
        drain();
        bus.pc_in    = 32'h80;
        bus.redirect = 1'b1;
        applyStimulus(1);
        memLat            = 3;
        bus.inst_ready    = 1'b0;
        bus.mem_req_ready = 1'b1;
        applyStimulus(3);
        bus.mem_req_ready = 1'b0;
        applyStimulus(1);
        checkOutput("t4_resp_in_redirect", bus.mem_resp_valid, 64'd1);
        bus.pc_in    = 32'h90;
        bus.redirect = 1'b1;
        applyStimulus(1);
        checkOutput("t4_discard", dut.discard_q, 64'd1);
        checkOutput("t4_inst_valid", bus.inst_valid, 64'd0);
        bus.mem_req_ready = 1'b1;
        bus.inst_ready    = 1'b1;
        memLat            = 1;
        idx               = logPc.size();
        applyStimulus(10);
        checkLog("t4_first_pc", idx, 32'h90);

        // Asynchronous reset mid-stream with 2 queued and 2 outstanding.
        drain();
        bus.inst_ready    = 1'b0;
        bus.mem_req_ready = 1'b1;
        memLat            = 1;
        applyStimulus(2);
        memLat = 10;
        applyStimulus(2);
        checkOutput("t5_pre_inst_valid", bus.inst_valid, 64'd1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("t5_inst_valid", bus.inst_valid, 64'd0);
        checkOutput("t5_inst_data", bus.inst_data, 64'd0);
        checkOutput("t5_inst_pc", bus.inst_pc, 64'd0);
        checkOutput("t5_req_valid", bus.mem_req_valid, 64'd0);
        checkOutput("t5_pc_advance", bus.pc_advance, 64'd0);
`ifdef FETCH_PERF_EN
        checkOutput("t5_perf_stall_rst", perfStall, 64'd0);
        checkOutput("t5_perf_drop_rst", perfDrop, 64'd0);
`endif
        memAddrQ.delete();
        memDueQ.delete();
        expQ.delete();
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = 32'h0;
        startPc            = bus.pc_in;
        @(posedge clk);
        cycle++;
        #1;
        reset = 1'b1;

        // Memory stalls for 7 cycles while a request is pending.
        bus.mem_req_ready = 1'b0;
        bus.inst_ready    = 1'b1;
        memLat            = 1;
        applyStimulus(7);
`ifdef FETCH_PERF_EN
        checkOutput("perf_stall", perfStall, 64'd7);
`endif
        bus.mem_req_ready = 1'b1;
        idx               = logPc.size();
        applyStimulus(6);
        checkLog("t5_first_pc", idx, startPc);

        // Second redirect run; drop counter sees exactly three discards.
        drain();
        redirectScenario(32'hC0, 32'hD0, "t6");
`ifdef FETCH_PERF_EN
        checkOutput("perf_drop", perfDrop, 64'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
